btn_debouncer: RTL and testbench
================================

# btn_debouncer

Front-end conditioning stage for the push-button inputs. Synchronises the raw, asynchronous, bouncing `btns` pads to `clk`, filters contact bounce with a per-button stability counter, and presents clean levels plus one-cycle press/release pulses. Sits directly upstream of the button interpreter, which consumes `btns_clean` in place of the raw pads.

## Interface
- `N_BTNS`, 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles a new synchronised level must hold before it is accepted (10 ms at 50 MHz). Legal range ≥ 2.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES)`: counter width, derived, not overridden.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btns_raw`  in  N_BTNS  raw pad levels, active-high, asynchronous to `clk`.
- `btns_clean`  out  N_BTNS  debounced level per button, registered.
- `btns_rise`  out  N_BTNS  one-cycle pulse when the clean level goes 0→1 (press).
- `btns_fall`  out  N_BTNS  one-cycle pulse when the clean level goes 1→0 (release).

## Operation
- Per channel: 2-flop synchroniser `s1 → s2`, stable register `stable`, counter `cnt[CNT_W-1:0]`.
- Two states per channel, encoded by `cnt`:
  - IDLE (`cnt == 0`, `s2 == stable`): hold.
  - CONFIRM (`s2 != stable`): `cnt` increments each cycle.
- Any cycle with `s2 == stable`: `cnt <= 0`, return to IDLE (bounce discarded, no output change).
- Cycle with `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`, assert `btns_rise` (new level 1) or `btns_fall` (new level 0) for that cycle only.
- Counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap.
- Channels fully independent; several channels may change and pulse in the same cycle. Priority among buttons is the interpreter's job, not this block's.
- `btns_rise` and `btns_fall` of one channel are never high together.

## Timing
- Reset (async assert, sync release through the flops): `s1`, `s2`, `stable`, `cnt` = 0; `btns_clean`, `btns_rise`, `btns_fall` = 0.
- Latency: raw level changes before edge 0 and then holds → `s2` reflects it after edge 1 → `btns_clean` and the matching pulse update after edge `DEBOUNCE_CYCLES+1` (i.e. `DEBOUNCE_CYCLES+2` edges).
- Pulse width exactly one `clk` cycle, coincident with the `btns_clean` transition.
- Glitch filter: any excursion on `s2` lasting ≤ `DEBOUNCE_CYCLES-1` cycles produces no output activity.
- Button held through reset release: treated as a fresh 0→1; `btns_clean` rises with a `btns_rise` pulse `DEBOUNCE_CYCLES+2` edges after `rst_n` deasserts.
- Reset mid-CONFIRM: counter and outputs clear immediately; pending change is discarded.

## Structure
- Shared header `btn_defs.vh`: `N_BTNS` and default `DEBOUNCE_CYCLES` constant, so top level, interpreter and LED mapper agree on the button count.
- One sub-module, `debounce_cell`: single-channel synchroniser + counter + stable register + edge pulses; instantiated `N_BTNS` times via generate loop. Top level is the generate loop and port bundling only.

## Test plan
All with `DEBOUNCE_CYCLES = 4`.
- Reset: hold `rst_n = 0` with `btns_raw = 4'b1111` → all outputs 0 throughout; no pulses.
- Clean press: `btns_raw[0]` 0→1 before edge 0, held → `btns_clean = 4'b0001` and `btns_rise = 4'b0001` after edge 5; `btns_rise` back to 0 after edge 6.
- Bounce rejection: `btns_raw[1]` high for 3 cycles, low 2, high 3, low → `btns_clean[1]` stays 0, no pulses; then high for 6 cycles → rise after 6th edge of the hold.
- Release: from `btns_clean = 4'b0100`, drop `btns_raw[2]` → `btns_fall = 4'b0100` one cycle, `btns_clean = 0`, 6 edges later.
- Simultaneous: `btns_raw` 0000→1001 in one cycle → `btns_rise = 4'b1001` in a single cycle, `btns_clean = 4'b1001`.
- Reset mid-CONFIRM: raise `btns_raw[3]`, pulse `rst_n` low at edge 3 → no rise; after release with button still held, rise arrives `DEBOUNCE_CYCLES+2` edges later.

Source files
------------

// File: rtl/btn_debouncer_pkg.sv
// Shared button-path definitions: channel count, default debounce window,
// and the per-channel confirmation state type.
package btn_debouncer_pkg;

    localparam int unsigned BTN_COUNT               = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic {
        IDLE,
        CONFIRM
    } cell_state_t;

endpackage

// File: rtl/btn_debouncer_cell.sv
// Single-channel debouncer: 2-flop synchroniser, stability counter,
// accepted level register and registered press/release pulses.
module debounce_cell
    import btn_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             rise_q;
    logic             fall_q;
    logic [CNT_W-1:0] cnt;

    logic             stable_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    cell_state_t      state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            stable <= stable_nxt;
            cnt    <= cnt_nxt;
            rise_q <= rise_nxt;
            fall_q <= fall_nxt;
        end
    end

    // The counter doubles as the state: any agreeing cycle discards progress.
    always_comb begin
        state      = (s2 != stable) ? CONFIRM : IDLE;
        stable_nxt = stable;
        cnt_nxt    = '0;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
            end
            CONFIRM: begin
                if (cnt == CNT_LAST) begin
                    stable_nxt = s2;
                    rise_nxt   = s2;
                    fall_nxt   = ~s2;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        clean = stable;
        rise  = rise_q;
        fall  = fall_q;
    end

endmodule

// File: rtl/btn_debouncer.sv
// Push-button front end: one independent debounce_cell per button,
// bundled into clean-level and press/release pulse vectors.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int unsigned N_BTNS          = BTN_COUNT,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BTNS-1:0] btns_raw,
    output logic [N_BTNS-1:0] btns_clean,
    output logic [N_BTNS-1:0] btns_rise,
    output logic [N_BTNS-1:0] btns_fall
);

    for (genvar i = 0; i < N_BTNS; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btns_raw[i]),
            .clean(btns_clean[i]),
            .rise (btns_rise[i]),
            .fall (btns_fall[i])
        );
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer with a 4-cycle window: vector table, hand-written
// corner sequences, then random stimulus against a sliding-window model.
module tb_btn_debouncer;

    localparam int unsigned N = 4;
    localparam int unsigned D = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btns_raw;
    logic [N-1:0] btns_clean;
    logic [N-1:0] btns_rise;
    logic [N-1:0] btns_fall;

    int n_pass  = 0;
    int n_total = 0;

    btn_debouncer #(
        .N_BTNS         (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btns_raw  (btns_raw),
        .btns_clean(btns_clean),
        .btns_rise (btns_rise),
        .btns_fall (btns_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the clean level flips once the last D synchronised
    // samples all disagree with it; samples are raw values delayed two edges.
    logic [N-1:0] m_clean;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
    logic [N-1:0] win[$];

    task automatic model_reset();
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        win.delete();
        for (int k = 0; k < D + 1; k++) win.push_back('0);
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < N; ch++) begin
                bit flip;
                flip = 1'b1;
                for (int k = 1; k <= D; k++)
                    if (win[win.size() - 1 - k][ch] == m_clean[ch]) flip = 1'b0;
                if (flip) begin
                    m_clean[ch] = ~m_clean[ch];
                    m_rise[ch]  = m_clean[ch];
                    m_fall[ch]  = ~m_clean[ch];
                end
            end
            win.push_back(btns_raw);
            void'(win.pop_front());
        end
    end

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step(input string nm, input logic r, input logic [N-1:0] raw,
                        input logic [N-1:0] ec, input logic [N-1:0] er, input logic [N-1:0] ef);
        @(negedge clk);
        rst_n    = r;
        btns_raw = raw;
        @(posedge clk);
        #1;
        chk({nm, ".clean"}, btns_clean, ec);
        chk({nm, ".rise"},  btns_rise,  er);
        chk({nm, ".fall"},  btns_fall,  ef);
    endtask

    typedef struct {
        logic         r;
        logic [N-1:0] raw;
        logic [N-1:0] clean;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic r, input logic [N-1:0] raw,
                       input logic [N-1:0] c, input logic [N-1:0] ri, input logic [N-1:0] f);
        vec_t v;
        v.r = r; v.raw = raw; v.clean = c; v.rise = ri; v.fall = f;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    initial begin
        rst_n    = 1'b0;
        btns_raw = 4'b1111;

        // held in reset with all buttons pressed, then released while held
        add(4, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(5, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
        add(1, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        add(5, 1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // clean press and release of button 0
        add(5, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        add(1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(5, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // simultaneous press and release of buttons 0 and 3
        add(5, 1, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1, 4'b1001, 4'b1001, 4'b1001, 4'b0000);
        add(1, 1, 4'b1001, 4'b1001, 4'b0000, 4'b0000);
        add(5, 1, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1001);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        foreach (tbl[i])
            step($sformatf("tbl[%0d]", i), tbl[i].r, tbl[i].raw, tbl[i].clean, tbl[i].rise, tbl[i].fall);

        // bounce on button 1: 3 high, 2 low, 3 high, 3 low -> nothing
        for (int k = 0; k < 3; k++) step("bounce", 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 2; k++) step("bounce", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) step("bounce", 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) step("bounce", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) step("bounce_hold", 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        step("bounce_rise", 1, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
        for (int k = 0; k < 5; k++) step("bounce_rel", 1, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        step("bounce_fall", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0010);

        // release of button 2 from a settled press
        for (int k = 0; k < 5; k++) step("b2_press", 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        step("b2_rise", 1, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
        step("b2_held", 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) step("b2_drop", 1, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        step("b2_fall", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        step("b2_idle", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // reset in the middle of confirming button 3; pending change discarded
        for (int k = 0; k < 3; k++) step("mid_cfm", 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        step("mid_rst", 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) step("post_rst", 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        step("post_rst_rise", 1, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
        step("post_rst_held", 1, 4'b1000, 4'b1000, 4'b0000, 4'b0000);

        // async reset clears a settled clean level without waiting for a clock
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_clr.clean", btns_clean, 4'b0000);
        step("async_hold", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("async_rel", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // random stimulus against the model, with varying bounce rates and occasional resets
        for (int blk = 0; blk < 30; blk++) begin
            int unsigned rate;
            rate = $urandom_range(2, 12);
            for (int c = 0; c < 100; c++) begin
                logic [N-1:0] nxt;
                @(negedge clk);
                nxt = btns_raw;
                for (int ch = 0; ch < N; ch++)
                    if ($urandom_range(0, rate - 1) == 0) nxt[ch] = ~nxt[ch];
                btns_raw = nxt;
                rst_n    = ($urandom_range(0, 299) != 0);
                @(posedge clk);
                #1;
                chk("rnd.clean", btns_clean, m_clean);
                chk("rnd.rise",  btns_rise,  m_rise);
                chk("rnd.fall",  btns_fall,  m_fall);
                chk("rnd.excl",  btns_rise & btns_fall, 4'b0000);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
